// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Desc     : Shared RV32 size codes, FSM state encoding and decode helpers
//            for the load/store unit.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STORE  = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        RESP   = 3'd5
    } lsu_state_e;

    // Codes 011/11x never exist; an unsigned halfword store is also rejected.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && (f3 == F3_HU));
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Desc     : Combinational lane logic: load extract/extend and store merge.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_ld_word,
    input  logic [1:0]        i_ld_off,
    input  logic [2:0]        i_ld_funct3,
    output logic [DATA_W-1:0] o_ld_data,
    input  logic [DATA_W-1:0] i_st_old,
    input  logic [DATA_W-1:0] i_st_wdata,
    input  logic [1:0]        i_st_off,
    input  logic [1:0]        i_st_size,
    output logic [DATA_W-1:0] o_st_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_signed;

    always_comb begin
        w_byte   = i_ld_word[{i_ld_off, 3'b000} +: 8];
        w_half   = i_ld_word[{i_ld_off[1], 4'b0000} +: 16];
        w_signed = (i_ld_funct3 != F3_BU) && (i_ld_funct3 != F3_HU);
        case (i_ld_funct3 & 3'b011)
            F3_B:    o_ld_data = {{(DATA_W-8){w_signed & w_byte[7]}}, w_byte};
            F3_H:    o_ld_data = {{(DATA_W-16){w_signed & w_half[15]}}, w_half};
            default: o_ld_data = i_ld_word;
        endcase
    end

    // Halfword lanes use only offset bit 1, so a low-bit misalignment folds down.
    always_comb begin
        o_st_word = i_st_old;
        case ({1'b0, i_st_size})
            F3_B:    o_st_word[{i_st_off, 3'b000} +: 8]     = i_st_wdata[7:0];
            F3_H:    o_st_word[{i_st_off[1], 4'b0000} +: 16] = i_st_wdata[15:0];
            default: o_st_word = i_st_wdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ctrl
// Desc     : RV32 load/store unit in front of a word-only memory; sub-word
//            stores are done as read-modify-write.
// Options  : LSU_MISALIGN_CHK_EN - report misaligned H/HU/W accesses as errors
// Revision : 1.0 - initial release
// ============================================================================
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_e        r_state;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_merge;
    logic [DATA_W-1:0] r_rdata;
    logic              r_valid;
    logic              r_err;
    logic              w_req_err;
    logic [DATA_W-1:0] w_ld_data;
    logic [DATA_W-1:0] w_st_word;

    always_comb begin
        w_req_err = f3_illegal(req_we, req_funct3);
`ifdef LSU_MISALIGN_CHK_EN
        if ((req_funct3[1:0] == 2'b01) && req_addr[0])
            w_req_err = 1'b1;
        if ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00))
            w_req_err = 1'b1;
`endif
    end

    lsu_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .i_ld_word   (mem_rdata),
        .i_ld_off    (r_addr[1:0]),
        .i_ld_funct3 (r_funct3),
        .o_ld_data   (w_ld_data),
        .i_st_old    (r_merge),
        .i_st_wdata  (r_wdata),
        .i_st_off    (r_addr[1:0]),
        .i_st_size   (r_funct3[1:0]),
        .o_st_word   (w_st_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_merge  <= '0;
            r_rdata  <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_rdata  <= '0;
                        r_err    <= w_req_err;
                        if (w_req_err) begin
                            r_valid <= 1'b1;
                            r_state <= RESP;
                        end else if (!req_we) begin
                            r_state <= LOAD;
                        end else if (req_funct3 == F3_W) begin
                            r_state <= STORE;
                        end else begin
                            r_state <= RMW_RD;
                        end
                    end
                end
                LOAD: begin
                    r_rdata <= w_ld_data;
                    r_valid <= 1'b1;
                    r_state <= RESP;
                end
                STORE: begin
                    r_valid <= 1'b1;
                    r_state <= RESP;
                end
                RMW_RD: begin
                    r_merge <= mem_rdata;
                    r_state <= RMW_WR;
                end
                RMW_WR: begin
                    r_valid <= 1'b1;
                    r_state <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Strobes are gated by rst so an aborted RMW never commits its write.
    assign mem_read   = !rst && ((r_state == LOAD) || (r_state == RMW_RD));
    assign mem_write  = !rst && ((r_state == STORE) || (r_state == RMW_WR));
    assign mem_addr   = {r_addr[ADDR_W-1:2], 2'b00};
    assign mem_wdata  = (r_state == STORE)  ? r_wdata :
                        (r_state == RMW_WR) ? w_st_word : '0;
    assign req_ready  = (r_state == IDLE);
    assign resp_valid = r_valid;
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_ctrl
// Desc     : Scoreboard bench for lsu_ctrl with a word memory and a
//            byte-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic        init_mem = 1'b1;

    assign mem_rdata = mem_read ? mem[mem_addr[9:2]] : 32'h0;

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        end else if (mem_write) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          acc_cyc = 0, rise_cyc = 0;
    int          rd_cnt = 0, wr_cnt = 0, rd_snap = 0, wr_snap = 0;
    logic        prev_valid = 1'b0;
    logic        hold = 1'b0;
    logic [31:0] cur_addr = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Expected response from byte-level arithmetic on the shadow memory.
    function automatic exp_t model(input logic we, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] wd);
        exp_t        e;
        int          idx = int'(a[9:2]);
        logic [31:0] w = ref_mem[idx];
        int          bsh = 8 * a[1:0];
        int          hsh = 16 * a[1];
        logic [31:0] b = (w >> bsh) & 32'hFF;
        logic [31:0] h = (w >> hsh) & 32'hFFFF;
        logic [31:0] mask;
        e.rdata = 32'h0; e.nrd = 0; e.nwr = 0;
        e.err = (f3 == 3) || (f3 == 6) || (f3 == 7) || (we && f3 == 5);
`ifdef LSU_MISALIGN_CHK_EN
        if ((f3 == 1 || f3 == 5) && a[0]) e.err = 1'b1;
        if (f3 == 2 && a[1:0] != 2'b00) e.err = 1'b1;
`endif
        if (e.err) begin
            e.lat = 1;
        end else if (!we) begin
            e.lat = 2; e.nrd = 1;
            case (f3)
                3'd0: e.rdata = (b >= 128) ? (b | 32'hFFFF_FF00) : b;
                3'd1: e.rdata = (h >= 32768) ? (h | 32'hFFFF_0000) : h;
                3'd4: e.rdata = b;
                3'd5: e.rdata = h;
                default: e.rdata = w;
            endcase
        end else if (f3 == 2) begin
            e.lat = 2; e.nwr = 1;
            ref_mem[idx] = wd;
        end else begin
            e.lat = 3; e.nrd = 1; e.nwr = 1;
            if (f3 == 1) begin
                mask = 32'hFFFF << hsh;
                ref_mem[idx] = (w & ~mask) | ((wd & 32'hFFFF) << hsh);
            end else begin
                mask = 32'hFF << bsh;
                ref_mem[idx] = (w & ~mask) | ((wd & 32'hFF) << bsh);
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (mem_read) rd_cnt++;
            if (mem_write) wr_cnt++;
            if (mem_read || mem_write)
                chk("mem_addr", mem_addr, {cur_addr[31:2], 2'b00});
            if (req_valid && req_ready) begin
                acc_cyc = cyc; rd_snap = rd_cnt; wr_snap = wr_cnt;
            end
            if (resp_valid && !prev_valid) rise_cyc = cyc;
            prev_valid = resp_valid;
            if (resp_valid && resp_ready) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_resp: actual rdata %h err %b required none", resp_rdata, resp_err);
                end else begin
                    e = q.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
                    chk("latency", rise_cyc - acc_cyc, e.lat);
                    chk("mem_reads", rd_cnt - rd_snap, e.nrd);
                    chk("mem_writes", wr_cnt - wr_snap, e.nwr);
                end
                done_cnt++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            resp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int n = 0;
        q.push_back(model(we, f3, a, wd));
        @(posedge clk); #1;
        cur_addr = a; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready) begin
            if (++n > 100) begin
                $display("FAIL accept_timeout: actual req_ready 0 required 1");
                $fatal(1, "request never accepted");
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target) begin
            if (++n > 200) begin
                $display("FAIL resp_timeout: actual done %0d required %0d", done_cnt, target);
                $fatal(1, "response never arrived");
            end
            @(negedge clk);
        end
    endtask

    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int t = done_cnt + 1;
        send(we, f3, a, wd);
        wait_done(t);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
        chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
    endtask

    initial begin
        logic [31:0] held, r;
        logic        we;
        logic [2:0]  f3;
        int          t, n;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0; init_mem = 1'b0;
        @(negedge clk);
        chk_reset_outputs();

        txn(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        chk("mem_word4_sw", mem[4], 32'hDEADBEEF);
        txn(1'b0, 3'd2, 32'h10, 32'h0);
        txn(1'b1, 3'd0, 32'h11, 32'h0000_0055);
        chk("mem_word4_sb", mem[4], 32'hDEAD55EF);
        txn(1'b0, 3'd2, 32'h10, 32'h0);
        txn(1'b1, 3'd2, 32'h10, 32'h8000_80F0);
        txn(1'b0, 3'd0, 32'h10, 32'h0);
        txn(1'b0, 3'd4, 32'h10, 32'h0);
        txn(1'b0, 3'd1, 32'h12, 32'h0);
        txn(1'b0, 3'd5, 32'h12, 32'h0);
        txn(1'b0, 3'd2, 32'h13, 32'h0);
        txn(1'b1, 3'd3, 32'h14, 32'h1234);
        txn(1'b1, 3'd5, 32'h14, 32'h1234);

        // Response back-pressure: outputs must hold and new requests stall.
        hold = 1'b1;
        t = done_cnt + 1;
        send(1'b0, 3'd2, 32'h10, 32'h0);
        n = 0;
        while (!resp_valid) begin
            if (++n > 20) begin
                $display("FAIL hold_valid_timeout: actual resp_valid 0 required 1");
                $fatal(1, "no response under hold");
            end
            @(negedge clk);
        end
        held = resp_rdata;
        @(posedge clk); #1;
        req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h30; req_wdata = 32'hCAFE_F00D;
        req_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("hold_resp_valid", {31'b0, resp_valid}, 32'd1);
            chk("hold_resp_rdata", resp_rdata, held);
            chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        hold = 1'b0;
        wait_done(t);
        chk("ignored_store", mem[12], 32'h0);

        // Reset during the write half of a halfword RMW.
        txn(1'b1, 3'd2, 32'h20, 32'h1234_5678);
        @(posedge clk); #1;
        cur_addr = 32'h20; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h20; req_wdata = 32'hAAAA;
        req_valid = 1'b1;
        @(negedge clk);
        n = 0;
        while (!req_ready) begin
            if (++n > 100) begin
                $display("FAIL rmw_accept_timeout: actual req_ready 0 required 1");
                $fatal(1, "rmw request never accepted");
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("rmw_wr_active", {31'b0, mem_write}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_gates_write", {31'b0, mem_write}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs();
        chk("rmw_abort_mem", mem[8], 32'h1234_5678);
        txn(1'b0, 3'd2, 32'h20, 32'h0);

        for (int k = 0; k < 250; k++) begin
            r  = $urandom();
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if (we && f3 == 3'd4) f3 = 3'd0;
            txn(we, f3, (r & 32'hFFFF_FC00) | (32'($urandom_range(0, 7)) << 2) | (r & 32'h3), $urandom());
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
